reg_dump_ctrl: RTL and testbench

Read-side initiator for the 32x32 register file. On a start pulse it walks a register address range through one register-file read port and streams each (address, word) pair out over a valid/ready handshake. It replaces the simulation-only end-of-run register dump with a synthesizable path, feeding the debug/trace sink or a bench monitor. It sits beside the datapath and shares the register file's second read port through an external mux.

---
 rtl/reg_dump_ctrl_pkg.sv | 17 +
 rtl/reg_dump_ctrl.sv | 129 ++++++++++++
 tb/tb_reg_dump_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_ctrl_pkg.sv
// Shared types and constants for the register-file dump controller.
// FSM encodings, register-file geometry and the data reset word.
package reg_dump_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Walks a register address range through one register-file read port and streams
// (address, word) pairs over valid/ready. Optional checksum output: REG_DUMP_CHECKSUM_EN.
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = REG_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
`ifdef REG_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] dump_csum
`endif
);

  dump_state_e       state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [ADDR_W-1:0] last, last_d;
  logic              valid_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic [ADDR_W-1:0] ptr_inc;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_d;
`endif

  // The read port address is the pointer register itself, so it is stable for the whole ADDR cycle.
  assign rf_read_reg = ptr;

  // Address arithmetic wraps at NUM_REGS, which need not be a power of two.
  assign ptr_inc = (ptr == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr + ADDR_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state;
    ptr_d   = ptr;
    last_d  = last;
    valid_d = dump_valid;
    addr_d  = dump_addr;
    data_d  = dump_data;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d  = dump_csum;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          ptr_d   = first_reg;
          last_d  = last_reg;
          busy_d  = 1'b1;
          state_d = ST_ADDR;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_ADDR: begin
        data_d  = rf_read_data;
        addr_d  = ptr;
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (dump_valid && dump_ready) begin
          valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = dump_csum + dump_data;
`endif
          if (ptr == last) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            ptr_d   = ptr_inc;
            state_d = ST_ADDR;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      last       <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= DATA_W'(WORD_ZERO);
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      dump_csum  <= DATA_W'(WORD_ZERO);
`endif
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      last       <= last_d;
      dump_valid <= valid_d;
      dump_addr  <= addr_d;
      dump_data  <= data_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      dump_csum  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard bench for reg_dump_ctrl: stimulus pushes expected (addr, word) pairs,
// a negedge monitor pops and compares on every handshake.
module tb_reg_dump_ctrl;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [31:0] dump_csum;
`endif

  logic [31:0] regs [32];
  logic [31:0] cap  [32];
  exp_t        exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int last_hs_cyc = -1;
  int first_valid_cyc = -1;

  assign rf_read_data = regs[rf_read_reg];

  reg_dump_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .first_reg    (first_reg),
    .last_reg     (last_reg),
    .rf_read_reg  (rf_read_reg),
    .rf_read_data (rf_read_data),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_addr    (dump_addr),
    .dump_data    (dump_data),
    .busy         (busy),
    .done         (done)
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    .dump_csum    (dump_csum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: handshake happens at the next posedge when valid&&ready is seen here.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (dump_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (dump_valid && dump_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        cap[dump_addr] = dump_data;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {27'd0, dump_addr}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_addr", {27'd0, dump_addr}, {27'd0, e.addr});
          check("sb_data", dump_data, e.data);
        end
      end
    end
  end

  task automatic clear_stats();
    hs_cnt = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    last_hs_cyc = -1;
  endtask

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    int n;
    logic [4:0] a;
    n = int'(5'(l - f)) + 1;
    for (int i = 0; i < n; i++) begin
      a = 5'(f + 5'(i));
      exp_q.push_back('{addr: a, data: regs[a]});
    end
    @(posedge clk); #1;
    start = 1'b1; first_reg = f; last_reg = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen high; timeout counts as a failure.
  task automatic wait_done(input string name, input int budget, output int t_done);
    t_done = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        t_done = cyc;
        break;
      end
    end
    if (t_done < 0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int t_d;
    bit found;

    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'(i) * 32'h0101_0101;
      cap[i]  = '0;
    end

    // Reset state
    #2;
    check("rst_rf_read_reg", {27'd0, rf_read_reg}, 32'd0);
    check("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_dump_addr", {27'd0, dump_addr}, 32'd0);
    check("rst_dump_data", dump_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: full range, ready high
    dump_ready = 1'b1;
    clear_stats();
    start_dump(5'd0, 5'd31);
    wait_done("t1", 200, t_d);
    check("t1_valid_to_done_fall", 32'(t_d + 1 - first_valid_cyc), 32'd64);
    check("t1_addr5_word", cap[5], 32'h0505_0505);
    check("t1_words", 32'(hs_cnt), 32'd32);
    @(negedge clk);
    check("t1_done_one_cycle", {31'd0, done}, 32'd0);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: wrapping range 30..1
    clear_stats();
    start_dump(5'd30, 5'd1);
    wait_done("t2", 50, t_d);
    idle_cycles(4);
    check("t2_words", 32'(hs_cnt), 32'd4);
    check("t2_done_count", 32'(done_cnt), 32'd1);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: single register, sink stalls 10 cycles
    clear_stats();
    dump_ready = 1'b0;
    start_dump(5'd7, 5'd7);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = dump_valid;
    end
    check("t3_valid_seen", {31'd0, found}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", {31'd0, dump_valid}, 32'd1);
      check("t3_hold_addr", {27'd0, dump_addr}, 32'd7);
      check("t3_hold_data", dump_data, 32'h0707_0707);
      if (i < 9) @(negedge clk);
    end
    @(posedge clk); #1;
    dump_ready = 1'b1;
    wait_done("t3", 20, t_d);
    check("t3_done_after_hs", 32'(t_d - last_hs_cyc), 32'd1);
    check("t3_words", 32'(hs_cnt), 32'd1);

    // 4: asynchronous reset while sending address 12
    clear_stats();
    start_dump(5'd0, 5'd31);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = dump_valid && (dump_addr == 5'd12);
    end
    check("t4_reached_12", {31'd0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", {31'd0, dump_valid}, 32'd0);
    check("t4_rst_addr", {27'd0, dump_addr}, 32'd0);
    check("t4_rst_data", dump_data, 32'd0);
    check("t4_rst_rf_read_reg", {27'd0, rf_read_reg}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    clear_stats();
    idle_cycles(5);
    check("t4_no_done", 32'(done_cnt), 32'd0);
    start_dump(5'd3, 5'd5);
    wait_done("t4", 50, t_d);
    idle_cycles(2);
    check("t4_words_after", 32'(hs_cnt), 32'd3);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: start while busy and during done is ignored
    clear_stats();
    start_dump(5'd0, 5'd2);
    @(posedge clk); #1;
    start = 1'b1; first_reg = 5'd20; last_reg = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", 50, t_d);
    #1;
    start = 1'b1; first_reg = 5'd9; last_reg = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(10);
    check("t5_words", 32'(hs_cnt), 32'd3);
    check("t5_done_count", 32'(done_cnt), 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef REG_DUMP_CHECKSUM_EN
    // 6: checksum wraps modulo 2^32
    regs[0] = 32'd1; regs[1] = 32'd2; regs[2] = 32'd3; regs[3] = 32'hFFFF_FFFF;
    clear_stats();
    start_dump(5'd0, 5'd3);
    wait_done("t6", 50, t_d);
    check("t6_csum", dump_csum, 32'h0000_0005);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
